pe_boot_ctrl: RTL and testbench
===============================

Name: pe_boot_ctrl

Overview:
- Command-side controller that generates the per-PE `conf_en` / `start_en` pair consumed by each PE's reset synchronizer.
- Sequences configuration, start and stop of up to NUM_PE processing elements.
- Waits out the synchronizer latency so `pe_running` reports that the PE is actually out of reset (or back in reset).
- Sits between the host/config-bus command decoder and the PE array.

Parameters:
- NUM_PE, 4: number of PEs controlled; width of the per-PE vectors.
- SYNC_LAT, 3: downstream reset-synchronizer depth in clk cycles; settle wait after START/STOP/CONF; must be ≥ 1.
- WDOG_W, 16: width of the configuration watchdog counter.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller accepts a command (high only in IDLE)
- cmd_op  in  2  00 NOP, 01 CONF, 10 START, 11 STOP
- cmd_mask  in  NUM_PE  PEs targeted by the command
- conf_done  in  1  single-cycle pulse from the instruction/config loader: load finished
- conf_en  out  NUM_PE  per-PE configuration-in-progress (holds PE in reset)
- start_en  out  NUM_PE  per-PE run enable
- pe_running  out  NUM_PE  PE reset released and settled
- busy  out  1  ~cmd_ready
- err  out  1  sticky watchdog timeout flag

Behaviour:
- Reset (async, rstn=0): all outputs 0 except cmd_ready=1; FSM→IDLE; counters 0. Applies at any point, including mid-command.
- Command acceptance: on cmd_valid & cmd_ready at edge T. All outputs are registered.
- NOP, or any op with cmd_mask=0:
  - accepted; no output change; remain IDLE.
- CONF, edge T:
  - start_en&=~mask; pe_running&=~mask; conf_en|=mask; err←0; wdog←0; →CONF.
  - CONF state: cmd_ready=0; wdog increments each cycle.
  - On conf_done=1: conf_en&=~mask; cnt←SYNC_LAT-1; →SETTLE.
  - conf_done while not in CONF is ignored.
- START, edge T:
  - start_en|=mask; cnt←SYNC_LAT-1; →SETTLE_RUN.
  - Bits already running are unaffected.
- SETTLE_RUN:
  - Decrement cnt.
  - At cnt=0: pe_running|=mask; →IDLE.
  - pe_running and cmd_ready rise at edge T+SYNC_LAT.
- STOP, edge T:
  - start_en&=~mask; pe_running&=~mask at edge T; cnt←SYNC_LAT-1; →SETTLE.
- SETTLE:
  - Decrement cnt; at cnt=0 →IDLE (cmd_ready=1 at edge T+SYNC_LAT).
  - Guarantees the downstream reset is asserted before the next command.
- The mask is latched at acceptance; cmd_mask changes afterwards have no effect.
- conf_en and start_en are never both 1 for the same PE.
- Simultaneous events: conf_done arriving in the same cycle as a watchdog expiry → conf_done wins (no err).

Optional Feature:
- Macro: PE_BOOT_WDOG_EN.
- With the macro defined:
  - In CONF, if wdog reaches 2^WDOG_W-1 with no conf_done: conf_en&=~mask; err←1; →SETTLE.
  - err stays set until the next accepted CONF or reset.
- Without the macro:
  - No watchdog counter; CONF waits indefinitely for conf_done.
  - err tied to 0.

Decomposition:
- Package pe_boot_pkg holds:
  - cmd_op encodings (OP_NOP/OP_CONF/OP_START/OP_STOP)
  - FSM state enum (IDLE, CONF, SETTLE_RUN, SETTLE)
  - default SYNC_LAT constant
- Sub-module pe_boot_wdog: clear/enable/expire counter, instantiated only under PE_BOOT_WDOG_EN.

Test Plan:
- CONF mask=4'b0011; conf_done 10 cycles later → conf_en=0011 for 10 cycles then 0000; cmd_ready returns 3 cycles after conf_done; pe_running=0000.
- START mask=0011 at edge T → start_en=0011 from T; pe_running=0011 and cmd_ready=1 at T+3.
- STOP mask=0001 while 0011 running → start_en=0010 and pe_running=0010 at edge T; cmd_ready at T+3.
- CONF mask=0010 while PE1 running → start_en[1] and pe_running[1] cleared at T with conf_en[1]=1; never conf_en&start_en on the same bit.
- With PE_BOOT_WDOG_EN, WDOG_W=4, no conf_done → at 15 cycles conf_en cleared, err=1, cmd_ready 3 cycles later; next CONF clears err.
- rstn pulsed low during SETTLE_RUN → all outputs 0 immediately, cmd_ready=1; a subsequent START behaves normally; cmd_mask=0 START → accepted, no state change.

Source files
------------

// File: rtl/pe_boot_pkg.sv
// Shared encodings for the PE boot controller: command opcodes, FSM states, default settle depth.
package pe_boot_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_CONF  = 2'b01,
    OP_START = 2'b10,
    OP_STOP  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    CONF       = 2'b01,
    SETTLE_RUN = 2'b10,
    SETTLE     = 2'b11
  } boot_state_e;

  localparam int SYNC_LAT_DEF = 3;

endpackage

// File: rtl/pe_boot_wdog.sv
// Configuration watchdog: cleared when a CONF is accepted, counts while enabled,
// flags expiry on the cycle the count reaches its all-ones value.
module pe_boot_wdog #(
  parameter int WDOG_W = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [WDOG_W-1:0] LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

  logic [WDOG_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_q + WDOG_W'(1);
  end

  // Fires on the edge where the counter steps onto all-ones.
  assign expire = en & ~clr & (cnt_q == LAST);

endmodule

// File: rtl/pe_boot_ctrl.sv
// Per-PE conf_en/start_en sequencer with reset-synchronizer settle tracking.
// Optional configuration watchdog enabled by defining PE_BOOT_WDOG_EN.
module pe_boot_ctrl
  import pe_boot_pkg::*;
#(
  parameter int NUM_PE   = 4,
  parameter int SYNC_LAT = SYNC_LAT_DEF,
  parameter int WDOG_W   = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [NUM_PE-1:0] cmd_mask,
  input  logic              conf_done,
  output logic [NUM_PE-1:0] conf_en,
  output logic [NUM_PE-1:0] start_en,
  output logic [NUM_PE-1:0] pe_running,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = (SYNC_LAT > 1) ? $clog2(SYNC_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SYNC_LAT - 1);

  boot_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_PE-1:0] mask_q, mask_d;
  logic [NUM_PE-1:0] conf_en_d, start_en_d, run_d;
  logic              ready_d, err_q, err_d;
  logic              act, wdog_exp;
  cmd_op_e           op;

  assign op  = cmd_op_e'(cmd_op);
  // Zero-mask commands are accepted but change nothing.
  assign act = cmd_valid & cmd_ready & (cmd_mask != '0);

`ifdef PE_BOOT_WDOG_EN
  logic wdog_clr, wdog_en;
  assign wdog_clr = act & (op == OP_CONF);
  assign wdog_en  = (state_q == CONF);

  pe_boot_wdog #(.WDOG_W(WDOG_W)) u_wdog (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (wdog_clr),
    .en     (wdog_en),
    .expire (wdog_exp)
  );
`else
  assign wdog_exp = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    conf_en_d  = conf_en;
    start_en_d = start_en;
    run_d      = pe_running;
    err_d      = err_q;
    unique case (state_q)
      IDLE: if (act) begin
        mask_d = cmd_mask;
        case (op)
          OP_CONF: begin
            start_en_d = start_en & ~cmd_mask;
            run_d      = pe_running & ~cmd_mask;
            conf_en_d  = conf_en | cmd_mask;
            err_d      = 1'b0;
            state_d    = CONF;
          end
          OP_START: begin
            start_en_d = start_en | cmd_mask;
            cnt_d      = CNT_LOAD;
            state_d    = SETTLE_RUN;
          end
          OP_STOP: begin
            start_en_d = start_en & ~cmd_mask;
            run_d      = pe_running & ~cmd_mask;
            cnt_d      = CNT_LOAD;
            state_d    = SETTLE;
          end
          default: ;
        endcase
      end
      // conf_done takes priority over a coincident watchdog expiry.
      CONF: if (conf_done) begin
        conf_en_d = conf_en & ~mask_q;
        cnt_d     = CNT_LOAD;
        state_d   = SETTLE;
      end else if (wdog_exp) begin
        conf_en_d = conf_en & ~mask_q;
        err_d     = 1'b1;
        cnt_d     = CNT_LOAD;
        state_d   = SETTLE;
      end
      SETTLE_RUN: if (cnt_q == '0) begin
        run_d   = pe_running | mask_q;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      SETTLE: if (cnt_q == '0) state_d = IDLE;
              else             cnt_d = cnt_q - CNT_W'(1);
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mask_q     <= '0;
      conf_en    <= '0;
      start_en   <= '0;
      pe_running <= '0;
      cmd_ready  <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      conf_en    <= conf_en_d;
      start_en   <= start_en_d;
      pe_running <= run_d;
      cmd_ready  <= ready_d;
      err_q      <= err_d;
    end
  end

  assign busy = ~cmd_ready;
  assign err  = err_q;

endmodule

// File: tb/tb_pe_boot_ctrl.sv
// Scoreboard bench for pe_boot_ctrl: tasks queue expected per-cycle output snapshots, a monitor pops and compares.
module tb_pe_boot_ctrl;
  localparam int N  = 4;
  localparam int SL = 3;
  localparam int WW = 4;

  logic         clk = 1'b0, rstn = 1'b0, cmd_valid = 1'b0, conf_done = 1'b0;
  logic [1:0]   cmd_op = 2'b00;
  logic [N-1:0] cmd_mask = '0;
  logic         cmd_ready, busy, err;
  logic [N-1:0] conf_en, start_en, pe_running;

  pe_boot_ctrl #(.NUM_PE(N), .SYNC_LAT(SL), .WDOG_W(WW)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .conf_done(conf_done),
    .conf_en(conf_en), .start_en(start_en), .pe_running(pe_running),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [N-1:0] ce, se, run;
    logic         rdy, er;
    string        nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0, checks = 0;
  logic [N-1:0] ce = '0, se = '0, run = '0;
  logic         er = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_span(input int c0, input int c1, input logic [N-1:0] e_ce,
                           input logic [N-1:0] e_se, input logic [N-1:0] e_run,
                           input logic e_rdy, input logic e_er, input string nm);
    for (int c = c0; c <= c1; c++) begin
      exp_t e;
      e.cyc = c; e.ce = e_ce; e.se = e_se; e.run = e_run; e.rdy = e_rdy; e.er = e_er; e.nm = nm;
      sb.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        checks++;
        if ((conf_en & start_en) !== '0) begin
          errors++;
          $display("FAIL overlap cyc=%0d conf_en=%b start_en=%b", cyc, conf_en, start_en);
        end
      end
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if ({conf_en, start_en, pe_running, cmd_ready, err} !== {e.ce, e.se, e.run, e.rdy, e.er}) begin
          errors++;
          $display("FAIL %s cyc=%0d got ce=%b se=%b run=%b rdy=%b err=%b want ce=%b se=%b run=%b rdy=%b err=%b",
                   e.nm, cyc, conf_en, start_en, pe_running, cmd_ready, err, e.ce, e.se, e.run, e.rdy, e.er);
        end
      end
    end
  endtask

  // Drives a command at a negedge; returns the cycle index of the accepting edge.
  task automatic send(input logic [1:0] op, input logic [N-1:0] m, output int t);
    @(negedge clk);
    t = cyc + 1;
    cmd_valid = 1'b1; cmd_op = op; cmd_mask = m;
  endtask

  // Drops the command and scrambles the mask to prove it was latched.
  task automatic fin();
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'b10; cmd_mask = '1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if ({conf_en, start_en, pe_running, cmd_ready, busy, err} !== {12'h000, 3'b100}) begin
      errors++;
      $display("FAIL reset got ce=%b se=%b run=%b rdy=%b busy=%b err=%b want 0,0,0,1,0,0",
               conf_en, start_en, pe_running, cmd_ready, busy, err);
    end
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_conf();
    int t;
    send(2'b01, 4'b0011, t);
    ce = 4'b0011; se &= ~4'b0011; run &= ~4'b0011; er = 1'b0;
    push_span(t, t + 9, ce, se, run, 1'b0, er, "conf_hold");
    push_span(t + 10, t + 12, 4'b0000, se, run, 1'b0, er, "conf_settle");
    push_span(t + 13, t + 13, 4'b0000, se, run, 1'b1, er, "conf_idle");
    fin();
    repeat (9) @(negedge clk);
    conf_done = 1'b1;
    @(negedge clk); conf_done = 1'b0;
    ce = '0;
    wait_drain(30);
  endtask

  task automatic do_start(input logic [N-1:0] m, input string nm);
    int t;
    send(2'b10, m, t);
    se |= m;
    push_span(t, t + SL - 1, ce, se, run, 1'b0, er, nm);
    run |= m;
    push_span(t + SL, t + SL, ce, se, run, 1'b1, er, nm);
    fin();
    wait_drain(20);
  endtask

  task automatic test_start();         do_start(4'b0011, "start");         endtask
  task automatic test_start_partial(); do_start(4'b0110, "start_partial"); endtask

  task automatic test_stop();
    int t;
    send(2'b11, 4'b0001, t);
    se &= ~4'b0001; run &= ~4'b0001;
    push_span(t, t + SL - 1, ce, se, run, 1'b0, er, "stop");
    push_span(t + SL, t + SL, ce, se, run, 1'b1, er, "stop_idle");
    fin();
    wait_drain(20);
  endtask

  task automatic test_conf_overlap();
    int t;
    send(2'b01, 4'b0010, t);
    se &= ~4'b0010; run &= ~4'b0010; ce = 4'b0010; er = 1'b0;
    push_span(t, t + 2, ce, se, run, 1'b0, er, "conf_ovl_hold");
    push_span(t + 3, t + 5, 4'b0000, se, run, 1'b0, er, "conf_ovl_settle");
    push_span(t + 6, t + 6, 4'b0000, se, run, 1'b1, er, "conf_ovl_idle");
    fin();
    repeat (2) @(negedge clk);
    conf_done = 1'b1;
    @(negedge clk); conf_done = 1'b0;
    ce = '0;
    wait_drain(20);
  endtask

  task automatic test_conf_done_idle();
    int t;
    @(negedge clk);
    t = cyc + 1;
    conf_done = 1'b1;
    push_span(t, t + 2, ce, se, run, 1'b1, er, "conf_done_idle");
    @(negedge clk); conf_done = 1'b0;
    wait_drain(10);
  endtask

  task automatic test_nop();
    int t;
    send(2'b00, 4'b1111, t);
    push_span(t, t + 2, ce, se, run, 1'b1, er, "nop");
    fin();
    wait_drain(10);
    send(2'b10, 4'b0000, t);
    push_span(t, t + 2, ce, se, run, 1'b1, er, "start_mask0");
    fin();
    wait_drain(10);
  endtask

  task automatic test_wdog();
`ifdef PE_BOOT_WDOG_EN
    int t;
    send(2'b01, 4'b1000, t);
    ce = 4'b1000; er = 1'b0;
    push_span(t, t + 14, ce, se, run, 1'b0, 1'b0, "wdog_hold");
    push_span(t + 15, t + 17, 4'b0000, se, run, 1'b0, 1'b1, "wdog_expire");
    push_span(t + 18, t + 18, 4'b0000, se, run, 1'b1, 1'b1, "wdog_idle");
    fin();
    ce = '0; er = 1'b1;
    wait_drain(40);
    send(2'b01, 4'b1000, t);
    push_span(t, t, 4'b1000, se, run, 1'b0, 1'b0, "wdog_err_clear");
    push_span(t + 1, t + 3, 4'b0000, se, run, 1'b0, 1'b0, "wdog_reconf_settle");
    push_span(t + 4, t + 4, 4'b0000, se, run, 1'b1, 1'b0, "wdog_reconf_idle");
    fin();
    conf_done = 1'b1;
    @(negedge clk); conf_done = 1'b0;
    er = 1'b0;
    wait_drain(20);
`else
    repeat (2) @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_tied got %b want 0", err);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int t;
    send(2'b10, 4'b0001, t);
    push_span(t, t, ce, se | 4'b0001, run, 1'b0, er, "pre_reset_start");
    fin();
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({conf_en, start_en, pe_running, cmd_ready, busy, err} !== {12'h000, 3'b100}) begin
      errors++;
      $display("FAIL reset_mid got ce=%b se=%b run=%b rdy=%b busy=%b err=%b want 0,0,0,1,0,0",
               conf_en, start_en, pe_running, cmd_ready, busy, err);
    end
    @(negedge clk); rstn = 1'b1;
    ce = '0; se = '0; run = '0; er = 1'b0;
    do_start(4'b0001, "start_after_reset");
  endtask

  initial begin
    fork monitor(); join_none
    test_reset();
    test_conf();
    test_start();
    test_stop();
    test_start_partial();
    test_conf_overlap();
    test_conf_done_idle();
    test_nop();
    test_wdog();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
